// File: rtl/ascon_pkg.sv
// ascon_pkg: shared constants, state encoding and helpers for the ASCON permutation core.
// Contents: lane width, round constant table C[0:11], per-lane rotation pairs,
//           FSM state enum, mode-to-round-count and rotate-right helpers.
package ascon_pkg;

    localparam int LANE_W = 64;
    localparam int ROUNDS = 12;

    // Round constant for round index i (0..11); p^a starts at index 12-a.
    localparam logic [7:0] RC [ROUNDS] = '{
        8'hf0, 8'he1, 8'hd2, 8'hc3, 8'hb4, 8'ha5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5a, 8'h4b
    };

    // Linear layer rotation pairs, lane x0..x4.
    localparam int ROT_A [5] = '{19, 61, 1, 10, 7};
    localparam int ROT_B [5] = '{28, 39, 6, 17, 41};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Reserved code 3 falls back to the full 12-round permutation.
    function automatic logic [3:0] mode_rounds(input logic [1:0] mode);
        return (mode == 2'd1) ? 4'd8 : (mode == 2'd2) ? 4'd6 : 4'd12;
    endfunction

    // Out-of-range indices only occur while the chain idles; they add nothing.
    function automatic logic [LANE_W-1:0] round_const(input logic [3:0] rnd);
        return (rnd < 4'd12) ? LANE_W'(RC[rnd]) : '0;
    endfunction

    function automatic logic [LANE_W-1:0] rotr(input logic [LANE_W-1:0] v, input int n);
        return (v >> n) | (v << (LANE_W - n));
    endfunction

endpackage

// File: rtl/ascon_round.sv
// ascon_round: one combinational ASCON round (constant addition, S-box, linear layer).
// Ports: state_in  - 320-bit state {x0..x4}, x0 in [319:256]
//        rnd       - round index 0..11 selecting the constant
//        state_out - state after the round, same packing
module ascon_round
    import ascon_pkg::*;
(
    input  logic [319:0] state_in,
    input  logic [3:0]   rnd,
    output logic [319:0] state_out
);

    logic [LANE_W-1:0] a [5];
    logic [LANE_W-1:0] b [5];
    logic [LANE_W-1:0] t [5];
    logic [LANE_W-1:0] c [5];
    logic [LANE_W-1:0] y [5];
    logic [LANE_W-1:0] z [5];

    always_comb begin
        for (int j = 0; j < 5; j++) begin
            a[j] = state_in[319-LANE_W*j -: LANE_W];
        end
        a[2] = a[2] ^ round_const(rnd);
        // Bitsliced S-box: input mixing, chi-like core, output mixing.
        b[0] = a[0] ^ a[4];
        b[1] = a[1];
        b[2] = a[2] ^ a[1];
        b[3] = a[3];
        b[4] = a[4] ^ a[3];
        for (int j = 0; j < 5; j++) begin
            t[j] = ~b[j] & b[(j+1)%5];
        end
        for (int j = 0; j < 5; j++) begin
            c[j] = b[j] ^ t[(j+1)%5];
        end
        y[0] = c[0] ^ c[4];
        y[1] = c[1] ^ c[0];
        y[2] = ~c[2];
        y[3] = c[3] ^ c[2];
        y[4] = c[4];
        for (int j = 0; j < 5; j++) begin
            z[j] = y[j] ^ rotr(y[j], ROT_A[j]) ^ rotr(y[j], ROT_B[j]);
            state_out[319-LANE_W*j -: LANE_W] = z[j];
        end
    end

endmodule

// File: rtl/ascon_perm_core.sv
// ascon_perm_core: iterated ASCON permutation p^12/p^8/p^6 with valid/ready on both sides.
// Ports: clk, rst_n (async active-low)
//        in_valid/in_ready/in_mode/in_state   - request side (mode 0:12, 1:8, 2:6, 3:12 rounds)
//        out_valid/out_ready/out_state        - result side, held until accepted
//        busy                                 - high while rounds are executing
// UNROLL (1 or 2) rounds are chained per clock.
module ascon_perm_core
    import ascon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   in_mode,
    input  logic [319:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [319:0] out_state,
    output logic         busy
);

    if (!(UNROLL == 1 || UNROLL == 2)) begin : g_bad_unroll
        $error("ascon_perm_core: UNROLL must be 1 or 2");
    end

    localparam logic [3:0] STEP = 4'(UNROLL);

    state_e        state_q, state_d;
    logic [3:0]    rnd_q, rnd_d;
    logic [319:0]  st_q, st_d;
    logic          out_valid_q, busy_q;
    logic [319:0]  chain [UNROLL+1];
    logic          accept;

    assign chain[0] = st_q;

    for (genvar g = 0; g < UNROLL; g++) begin : g_round
        ascon_round u_round (
            .state_in  (chain[g]),
            .rnd       (rnd_q + 4'(g)),
            .state_out (chain[g+1])
        );
    end

    // DONE admits a new request in the same cycle the result is taken, so no idle bubble.
    assign in_ready = rst_n & ((state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d = state_q;
        rnd_d   = rnd_q;
        st_d    = st_q;
        if (accept) begin
            state_d = ST_RUN;
            rnd_d   = 4'd12 - mode_rounds(in_mode);
            st_d    = in_state;
        end else if (state_q == ST_RUN) begin
            st_d    = chain[UNROLL];
            rnd_d   = rnd_q + STEP;
            state_d = (rnd_q + STEP == 4'd12) ? ST_DONE : ST_RUN;
        end else if (state_q == ST_DONE && out_ready) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rnd_q       <= '0;
            st_q        <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rnd_q       <= rnd_d;
            st_q        <= st_d;
            out_valid_q <= (state_d == ST_DONE);
            busy_q      <= (state_d == ST_RUN);
        end
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign out_state = st_q;

endmodule

// File: tb/tb_ascon_perm_core.sv
// tb_ascon_perm_core: self-checking bench for ascon_perm_core with UNROLL=1 and UNROLL=2 instances.
module tb_ascon_perm_core;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b1;
    logic         iv   [2];
    logic         ir   [2];
    logic         ov   [2];
    logic         ordy [2];
    logic         bz   [2];
    logic [1:0]   md   [2];
    logic [319:0] si   [2];
    logic [319:0] so   [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_acc [2] = '{0, 0};

    ascon_perm_core #(.UNROLL(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .in_mode(md[0]),
        .in_state(si[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_state(so[0]), .busy(bz[0])
    );

    ascon_perm_core #(.UNROLL(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .in_mode(md[1]),
        .in_state(si[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_state(so[1]), .busy(bz[1])
    );

    always #5 clk = ~clk;

    initial forever @(posedge clk) cyc++;

    // Reference model: S-box as a 32-entry lookup applied per column, x0 as the MSB.
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int RA [5] = '{19, 61, 1, 10, 7};
    localparam int RB [5] = '{28, 39, 6, 17, 41};
    localparam int SWEEP_LAT [4] = '{6, 4, 3, 6};

    function automatic int rounds_of(input logic [1:0] m);
        return (m == 2'd1) ? 8 : (m == 2'd2) ? 6 : 12;
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] v, input int n);
        return (v >> n) | (v << (64 - n));
    endfunction

    function automatic logic [319:0] perm(input logic [319:0] s, input int first, input int n);
        logic [63:0]  x [5];
        logic [4:0]   v;
        logic [319:0] r;
        for (int j = 0; j < 5; j++) x[j] = s[319-64*j -: 64];
        for (int i = first; i < first + n; i++) begin
            x[2] = x[2] ^ 64'(((15 - i) << 4) | i);
            for (int col = 0; col < 64; col++) begin
                v = SBOX[{x[0][col], x[1][col], x[2][col], x[3][col], x[4][col]}];
                x[0][col] = v[4];
                x[1][col] = v[3];
                x[2][col] = v[2];
                x[3][col] = v[1];
                x[4][col] = v[0];
            end
            for (int j = 0; j < 5; j++) x[j] = x[j] ^ ror(x[j], RA[j]) ^ ror(x[j], RB[j]);
        end
        for (int j = 0; j < 5; j++) r[319-64*j -: 64] = x[j];
        return r;
    endfunction

    function automatic logic [319:0] rand320();
        logic [319:0] r;
        for (int i = 0; i < 10; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Cycle-level expectation per instance: pending request with its deadline, then a held result.
    logic [319:0] eq [2][8];
    int hd [2]   = '{0, 0};
    int tl [2]   = '{0, 0};
    int acc [2]  = '{0, 0};
    int nexp [2] = '{0, 0};
    bit pend [2] = '{0, 0};
    bit done [2] = '{0, 0};
    bit erdy;

    initial begin
        forever begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (!rst_n) begin
                    chk("rst_out_valid", 320'(ov[d]), 320'(0));
                    chk("rst_busy", 320'(bz[d]), 320'(0));
                    chk("rst_in_ready", 320'(ir[d]), 320'(0));
                    hd[d] = 0;
                    tl[d] = 0;
                    pend[d] = 0;
                    done[d] = 0;
                end else begin
                    if (pend[d] && cyc == acc[d] + nexp[d]) begin
                        pend[d] = 0;
                        done[d] = 1;
                    end
                    erdy = done[d] ? ordy[d] : !pend[d];
                    chk("out_valid", 320'(ov[d]), 320'(done[d]));
                    chk("busy", 320'(bz[d]), 320'(pend[d]));
                    chk("in_ready", 320'(ir[d]), 320'(erdy));
                    if (done[d]) chk("out_state", so[d], eq[d][hd[d]]);
                    if (done[d] && ordy[d]) begin
                        hd[d] = (hd[d] + 1) % 8;
                        done[d] = 0;
                    end
                    if (iv[d] && erdy) begin
                        eq[d][tl[d]] = perm(si[d], 12 - rounds_of(md[d]), rounds_of(md[d]));
                        tl[d] = (tl[d] + 1) % 8;
                        nexp[d] = rounds_of(md[d]) / (d + 1);
                        acc[d] = cyc + 1;
                        pend[d] = 1;
                    end
                end
            end
        end
    end

    // Callers start at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic req(input int d, input logic [319:0] s, input logic [1:0] m);
        bit ok;
        ok = 0;
        iv[d] = 1'b1;
        si[d] = s;
        md[d] = m;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (ir[d]) begin
                last_acc[d] = cyc + 1;
                ok = 1;
            end
        end
        chk("req_accepted", 320'(ok), 320'(1));
        @(posedge clk);
        #1 iv[d] = 1'b0;
    endtask

    task automatic wait_out(input int d, output int lat);
        bit ok;
        ok = 0;
        lat = -1;
        for (int k = 0; k < 200 && !ok; k++) begin
            @(negedge clk);
            if (ov[d]) begin
                lat = cyc - last_acc[d];
                ok = 1;
            end
        end
        chk("out_arrived", 320'(ok), 320'(1));
        @(posedge clk);
        #1;
    endtask

    task automatic pop(input int d);
        ordy[d] = 1'b1;
        @(posedge clk);
        #1 ordy[d] = 1'b0;
    endtask

    int lat;
    int prev;
    logic [319:0] p;

    initial begin
        for (int d = 0; d < 2; d++) begin
            iv[d] = 1'b0;
            ordy[d] = 1'b0;
            md[d] = 2'd0;
            si[d] = '0;
        end
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Hand-derived single round (index 11, constant 4b) from the all-zero state.
        p = perm('0, 11, 1);
        chk("pin_round11", p, {64'h000964B00000004B, 64'h0000000096000213,
                               64'h53FFFFFFFFFFFF90, 64'h12E580000000004B, 64'h0});
        chk("pin_p0_identity", perm(p, 0, 0), p);

        // ASCON-128 initialisation with zero key and nonce.
        req(0, {64'h80400c0600000000, 256'd0}, 2'd0);
        wait_out(0, lat);
        chk("lat_init_p12", 320'(lat), 320'(12));
        pop(0);

        // Round-count sweep on the two-rounds-per-clock instance.
        for (int m = 0; m < 4; m++) begin
            req(1, rand320(), 2'(m));
            wait_out(1, lat);
            chk("lat_sweep", 320'(lat), 320'(SWEEP_LAT[m]));
            pop(1);
        end

        // Backpressure: result held for 20 cycles while another request waits.
        req(0, rand320(), 2'd2);
        wait_out(0, lat);
        chk("lat_bp_p6", 320'(lat), 320'(6));
        iv[0] = 1'b1;
        si[0] = rand320();
        md[0] = 2'd1;
        repeat (20) @(posedge clk);
        #1 chk("bp_still_valid", 320'(ov[0]), 320'(1));
        ordy[0] = 1'b1;
        @(posedge clk);
        #1 ordy[0] = 1'b0;
        iv[0] = 1'b0;
        last_acc[0] = cyc;
        wait_out(0, lat);
        chk("lat_bp_next_p8", 320'(lat), 320'(8));
        pop(0);

        // Back-to-back p8 with out_ready tied high.
        ordy[0] = 1'b1;
        prev = 0;
        for (int i = 0; i < 4; i++) begin
            req(0, rand320(), 2'd1);
            if (i > 0) chk("b2b_gap", 320'(last_acc[0] - prev), 320'(9));
            prev = last_acc[0];
        end
        wait_out(0, lat);
        chk("lat_b2b_last", 320'(lat), 320'(8));
        ordy[0] = 1'b0;

        // Reset three cycles into a p12 run.
        req(0, rand320(), 2'd0);
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("midrst_out_valid", 320'(ov[0]), 320'(0));
        chk("midrst_busy", 320'(bz[0]), 320'(0));
        chk("midrst_in_ready", 320'(ir[0]), 320'(0));
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", 320'(ir[0]), 320'(1));
        @(posedge clk);
        #1;
        req(0, rand320(), 2'd2);
        wait_out(0, lat);
        chk("lat_post_rst", 320'(lat), 320'(6));
        pop(0);

        // in_mode wiggles after accept must not alter the round count.
        req(1, rand320(), 2'd2);
        md[1] = 2'd0;
        @(posedge clk);
        #1 md[1] = 2'd3;
        @(posedge clk);
        #1 md[1] = 2'd1;
        wait_out(1, lat);
        chk("lat_mode_sampled", 320'(lat), 320'(3));
        pop(1);

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) chk("drained", 320'(hd[d]), 320'(tl[d]));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
